// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared access-size codes, FSM states and alignment helper for the
//            MEM-stage data-memory access unit.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Little-endian lane steering: store byte enables / replicated data
//            and load lane selection with sign or zero extension.
// Revision : 1.0
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [1:0]  i_ld_addr,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_st_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = i_ld_rdata[7:0];
        case (i_ld_addr)
            2'd0:    w_byte = i_ld_rdata[7:0];
            2'd1:    w_byte = i_ld_rdata[15:8];
            2'd2:    w_byte = i_ld_rdata[23:16];
            default: w_byte = i_ld_rdata[31:24];
        endcase
    end

    assign w_half = i_ld_addr[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'h000000, w_byte}
                                               : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = i_ld_unsigned ? {16'h0000, w_half}
                                               : {{16{w_half[15]}}, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM-stage req/ack data-memory access with pipeline stall,
//            misalignment detection and ack timeout.
// Revision : 1.0
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        UnsignedM,
    input  logic [31:0] AluOutM,
    input  logic [31:0] WriteDataM,
    input  logic        holdM,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        busErrM
);
    import mem_pkg::*;

    localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_buserr;

    logic              w_acc;
    logic              w_misalign;
    logic              w_start;
    logic              w_busy;
    logic              w_timeout;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_wdata;
    logic [31:0]       w_ld_data;

    assign w_acc      = MemReadM | MemWriteM;
    assign w_misalign = w_acc & is_misaligned(SizeM, AluOutM[1:0]);
    assign w_start    = (r_state == ST_IDLE) & w_acc & ~w_misalign;
    assign w_busy     = (r_state == ST_BUSY);
    // An ack arriving on the last allowed cycle still completes normally.
    assign w_timeout  = w_busy & ~mem_ack & (r_cnt == c_to_last);

    mem_lane_align u_lane (
        .i_st_size     (SizeM),
        .i_st_addr     (AluOutM[1:0]),
        .i_st_wdata    (WriteDataM),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_uns),
        .i_ld_addr     (r_addr_lo),
        .i_ld_rdata    (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)              w_next = ST_BUSY;
            ST_BUSY: if (mem_ack || w_timeout) w_next = ST_DONE;
            ST_DONE: if (!holdM)               w_next = ST_IDLE;
            default:                           w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_addr_lo <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_buserr  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_buserr <= w_timeout;
            r_cnt    <= w_busy ? r_cnt + CNT_W'(1) : '0;
            if (w_start) begin
                r_addr    <= {AluOutM[31:2], 2'b00};
                r_addr_lo <= AluOutM[1:0];
                r_size    <= SizeM;
                r_uns     <= UnsignedM;
                r_we      <= MemWriteM;
                r_be      <= w_st_be;
                r_wdata   <= w_st_wdata;
            end
            if (w_busy) begin
                if (mem_ack) begin
                    r_rdata <= r_we ? 32'h0 : w_ld_data;
                end else if (w_timeout) begin
                    r_rdata <= 32'h0;
                end
            end
        end
    end

    assign mem_req   = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_be    = w_busy ? r_be : 4'b0000;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign stallM    = w_start | w_busy;
    assign misalignM = w_misalign;
    assign busErrM   = r_buserr;
    // A rejected misaligned access must not leak a stale load into latch4.
    assign readDataM = ((r_state == ST_IDLE) && w_misalign) ? 32'h0 : r_rdata;

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage pipelined MIPS core.
- Sits between the EX/MEM pipeline latch and the MEM/WB latch (latch4).
- Takes address (AluOutM), store data and access controls, and runs a req/ack transaction to external data memory. Formats load data into readDataM for latch4.
- Asserts stallM while a transaction is outstanding.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack before aborting with a bus error (>=2).
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage.
- SizeM  in  2  access size: byte / half / word.
- UnsignedM  in  1  zero-extend load (lbu/lhu) when 1.
- AluOutM  in  32  byte address.
- WriteDataM  in  32  store data, right-justified.
- holdM  in  1  hazard-unit freeze of the MEM/WB latch.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_req  out  1  transaction request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, AluOutM with bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- readDataM  out  32  formatted load data to latch4.
- stallM  out  1  freeze IF/ID/EX/MEM latches.
- misalignM  out  1  misaligned access flag.
- busErrM  out  1  timeout flag, 1-cycle pulse.

Behaviour:
- Reset: state IDLE, counter 0, all registered request fields 0. Outputs: mem_req 0, mem_we 0, mem_be 0, readDataM 0, busErrM 0. Reset mid-transaction drops mem_req immediately; a later mem_ack is ignored.
- Access condition: acc = MemReadM | MemWriteM.
- Read and write both set: treated as a store; readDataM 0.
- Alignment:
  - half needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned acc: misalignM=1 (combinational), no request, stallM=0, store suppressed, readDataM=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned acc:
    - stallM=1 combinationally.
    - Capture addr/we/be/wdata/size/unsigned.
    - Go to BUSY.
  - BUSY:
    - mem_req=1, stallM=1; mem_addr/mem_we/mem_be/mem_wdata come from the captured registers and are stable for the whole BUSY period.
    - Counter increments each BUSY cycle.
    - mem_ack: capture formatted load into readDataM (0 for stores), go to DONE.
    - Counter reaches TIMEOUT-1 without ack: readDataM=0, busErrM=1 for the DONE-entry cycle, go to DONE.
    - Ack in the same cycle as the timeout: ack wins, no error.
  - DONE:
    - stallM=0, mem_req=0, readDataM held.
    - holdM=1: stay in DONE.
    - holdM=0: go to IDLE at the edge, with readDataM sampled by latch4 at that edge.
  - mem_ack in IDLE or DONE is ignored.
- Latency: with ack in the k-th BUSY cycle (k>=1), stallM is high for k+1 cycles and the MEM stage occupies k+2 cycles.
- Byte enables and store data (little-endian):
  - byte: be = 1 << addr[1:0]; wdata = byte replicated x4.
  - half: be = 0011 (addr[1]=0) or 1100; wdata = half replicated x2.
  - word: be = 1111.
- Load formatting:
  - Select the lane by the captured addr.
  - Sign-extend unless unsigned; word loads pass through.
- Reserved size encoding 11: treated as word.

Decomposition:
- Package mem_pkg:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding IDLE/BUSY/DONE.
- One combinational sub-module, mem_lane_align:
  - Store side: size, addr[1:0], wdata -> be, replicated wdata.
  - Load side: size, unsigned, addr[1:0], rdata -> extended load.
- FSM, counter and capture registers stay in mem_access_stage.

Test Plan:
- lw: addr 0x100, ack in 1st BUSY cycle, rdata 0xDEADBEEF -> stallM high 2 cycles; mem_addr 0x100, be 1111; readDataM 0xDEADBEEF in DONE.
- lb / lbu: addr 0x103, rdata 0x80112233 -> be 1000; lb gives 0xFFFFFF80, lbu gives 0x00000080.
- sh: addr 0x202, WriteDataM 0x0000ABCD -> mem_we 1, be 1100, wdata 0xABCDABCD, mem_addr 0x200.
- lw at 0x101 -> misalignM=1, mem_req stays 0, stallM=0, readDataM=0.
- No ack for 16 BUSY cycles -> busErrM pulses once, readDataM=0, stallM falls. Repeat with ack in the 16th cycle -> no busErrM.
- clr pulsed in BUSY -> mem_req=0 immediately, state IDLE. Stray ack afterwards -> no effect. holdM=1 in DONE for 3 cycles -> readDataM held, stallM=0, DONE kept.
